// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
//   Bundles the three buses around the SRAM arbiter: instruction-fetch
//   requester (if_*), MEM-stage data requester (mem_*) and the external
//   SRAM pins (ram_*).
//   Modports:
//     slave  - arbiter side: takes requests and ram_rdata, drives acks, read
//              data, hold lines and the SRAM address/data/strobes.
//     master - CPU/SRAM side: the mirror image of slave.
//   Parameters: ADDR_W address width, DATA_W data width.
interface sram_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              if_hold;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_hold;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_dout_en;
  logic              ram_ce_n;
  logic              ram_oe_n;
  logic              ram_we_n;

  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  ram_rdata,
    output if_ack, if_rdata, if_hold,
    output mem_ack, mem_rdata, mem_hold,
    output ram_addr, ram_wdata, ram_dout_en, ram_ce_n, ram_oe_n, ram_we_n
  );

  modport master (
    output if_req, if_addr,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output ram_rdata,
    input  if_ack, if_rdata, if_hold,
    input  mem_ack, mem_rdata, mem_hold,
    input  ram_addr, ram_wdata, ram_dout_en, ram_ce_n, ram_oe_n, ram_we_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one asynchronous SRAM between instruction fetch and the MEM-stage
//   data port, with fixed priority MEM over IF (MEM holds the older
//   instruction). Sequences the SRAM strobes and raises hold lines that stall
//   the requesters until their access is acknowledged.
//   Ports:
//     clk            system clock, all state changes on posedge
//     rst            synchronous reset, active low
//     bus            sram_arbiter_if.slave: requester buses and SRAM pins
//     perf_if_stall  (SRAM_ARB_PERF_EN only) saturating count of if_hold cycles
//     perf_mem_ops   (SRAM_ARB_PERF_EN only) saturating count of mem_ack pulses
//   Build option: define SRAM_ARB_PERF_EN to add the two performance counters.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | arbitrate; grant MEM first, then IF; latch addr/data
//   IF_RD    | fetch read, ce_n=oe_n=0 for RD_CYCLES cycles
//   MEM_RD   | data read, ce_n=oe_n=0 for RD_CYCLES cycles
//   WR_SETUP | address/data setup, ce_n=0, dout_en=1, we_n=1
//   WR_PULSE | we_n=0 for WR_CYCLES cycles
//   WR_HOLD  | data hold after we_n rises, dout_en=1
//   DONE     | owner's ack high, strobes inactive, no grant
module sram_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int RD_CYCLES = 1,
  parameter int WR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  sram_arbiter_if.slave bus
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0] perf_if_stall,
  output logic [31:0] perf_mem_ops
`endif
);

  localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  // The counter only has to hold the reload value MAX_CYC-1.
  localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    IF_RD,
    MEM_RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  state_t            state_q, state_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic              grant, grant_mem;
  logic [ADDR_W-1:0] grant_addr;
  logic              cap_if, cap_mem;

  logic              ce_n_nx, oe_n_nx, we_n_nx, dout_en_nx;
  logic              if_ack_nx, mem_ack_nx;

  logic              ce_n_q, oe_n_q, we_n_q, dout_en_q;
  logic              if_ack_q, mem_ack_q;
  logic [DATA_W-1:0] if_rdata_q, mem_rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  always_comb begin
    state_nx  = state_q;
    cnt_nx    = cnt_q;
    grant     = 1'b0;
    grant_mem = 1'b0;
    cap_if    = 1'b0;
    cap_mem   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          grant     = 1'b1;
          grant_mem = 1'b1;
          if (bus.mem_we) begin
            state_nx = WR_SETUP;
            cnt_nx   = WR_LOAD;
          end else begin
            state_nx = MEM_RD;
            cnt_nx   = RD_LOAD;
          end
        end else if (bus.if_req) begin
          grant    = 1'b1;
          state_nx = IF_RD;
          cnt_nx   = RD_LOAD;
        end
      end
      IF_RD: begin
        if (cnt_q == '0) begin
          state_nx = DONE;
          cap_if   = 1'b1;
        end else begin
          cnt_nx = cnt_q - CNT_W'(1);
        end
      end
      MEM_RD: begin
        if (cnt_q == '0) begin
          state_nx = DONE;
          cap_mem  = 1'b1;
        end else begin
          cnt_nx = cnt_q - CNT_W'(1);
        end
      end
      WR_SETUP: state_nx = WR_PULSE;
      WR_PULSE: begin
        if (cnt_q == '0) begin
          state_nx = WR_HOLD;
        end else begin
          cnt_nx = cnt_q - CNT_W'(1);
        end
      end
      WR_HOLD: state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign grant_addr = grant_mem ? bus.mem_addr : bus.if_addr;

  // Strobes are decoded from the next state and registered, so the SRAM pins
  // never see a combinational path from the request lines.
  always_comb begin
    ce_n_nx    = 1'b1;
    oe_n_nx    = 1'b1;
    we_n_nx    = 1'b1;
    dout_en_nx = 1'b0;
    case (state_nx)
      IF_RD, MEM_RD: begin
        ce_n_nx = 1'b0;
        oe_n_nx = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        ce_n_nx    = 1'b0;
        dout_en_nx = 1'b1;
      end
      WR_PULSE: begin
        ce_n_nx    = 1'b0;
        we_n_nx    = 1'b0;
        dout_en_nx = 1'b1;
      end
      default: ;
    endcase
  end

  assign if_ack_nx  = cap_if;
  assign mem_ack_nx = cap_mem | (state_q == WR_HOLD);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dout_en_q   <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q   <= state_nx;
      cnt_q     <= cnt_nx;
      ce_n_q    <= ce_n_nx;
      oe_n_q    <= oe_n_nx;
      we_n_q    <= we_n_nx;
      dout_en_q <= dout_en_nx;
      if_ack_q  <= if_ack_nx;
      mem_ack_q <= mem_ack_nx;
      if (grant) begin
        addr_q <= grant_addr;
      end
      if (grant_mem) begin
        wdata_q <= bus.mem_wdata;
      end
      if (cap_if) begin
        if_rdata_q <= bus.ram_rdata;
      end
      if (cap_mem) begin
        mem_rdata_q <= bus.ram_rdata;
      end
    end
  end

  assign bus.ram_addr    = addr_q;
  assign bus.ram_wdata   = wdata_q;
  assign bus.ram_ce_n    = ce_n_q;
  assign bus.ram_oe_n    = oe_n_q;
  assign bus.ram_we_n    = we_n_q;
  assign bus.ram_dout_en = dout_en_q;
  assign bus.if_ack      = if_ack_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.mem_ack     = mem_ack_q;
  assign bus.mem_rdata   = mem_rdata_q;

  // Requesters stay held until the cycle their own ack is presented.
  assign bus.if_hold  = bus.if_req & ~if_ack_q;
  assign bus.mem_hold = bus.mem_req & ~mem_ack_q;

`ifdef SRAM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_if_stall <= '0;
      perf_mem_ops  <= '0;
    end else begin
      if (bus.if_hold && (perf_if_stall != 32'hFFFF_FFFF)) begin
        perf_if_stall <= perf_if_stall + 32'd1;
      end
      if (mem_ack_q && (perf_mem_ops != 32'hFFFF_FFFF)) begin
        perf_mem_ops <= perf_mem_ops + 32'd1;
      end
    end
  end
`endif

endmodule
